// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out stage driving a tbuf (Q -> data, EN -> enable).
// Define PISO_PARITY_EN to append an even-parity bit after each WIDTH-bit word.
module piso_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] D,
   input  logic             VALID,
   output logic             READY,
   output logic             Q,
   output logic             EN,
   output logic             LAST,
   output logic [1:0]       fsm_state
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   // Handshake: a word moves on a rising CLK edge where VALID and READY are both 1;
   // READY depends only on state and RESET, never on VALID.

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             final_bit;
   logic             last_cycle;
   logic             accept;
`ifdef PISO_PARITY_EN
   logic             par;
`endif

   assign final_bit = (state == SHIFT) && (cnt == '0);
`ifdef PISO_PARITY_EN
   assign last_cycle = (state == PAR);
`else
   assign last_cycle = final_bit;
`endif

   assign READY     = !RESET && ((state == IDLE) || last_cycle);
   assign accept    = VALID && READY;
   assign EN        = (state != IDLE);
   assign LAST      = last_cycle;
   assign fsm_state = state;

   always_comb begin
      Q = 1'b0;
      if (state == SHIFT) begin
         Q = shreg[WIDTH-1];
      end
`ifdef PISO_PARITY_EN
      else if (state == PAR) begin
         Q = par;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         case (state)
            SHIFT: begin
               shreg <= {shreg[WIDTH-2:0], 1'b0};
`ifdef PISO_PARITY_EN
               par   <= par ^ shreg[WIDTH-1];
`endif
               if (cnt == '0) begin
`ifdef PISO_PARITY_EN
                  state <= PAR;
`else
                  state <= IDLE;
`endif
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
               state <= IDLE;
               par   <= 1'b0;
            end
`endif
            default: state <= IDLE;
         endcase
         // An accept in IDLE or in the final emitted cycle overrides the above.
         if (accept) begin
            state <= SHIFT;
            shreg <= D;
            cnt   <= CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
            par   <= 1'b0;
`endif
         end
      end
   end

endmodule
